ball_ctl: RTL and testbench
===========================

BALL_CTL -- requirements
Module: ball_ctl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- RADIUS, 10, puck radius in pixels
- H_MAX, 1023, rightmost table column
- V_MAX, 767, bottom table row
- GOAL_TOP, 284, first row of the goal opening on both side walls
- GOAL_BOT, 484, last row of the goal opening
- START_X, 512, serve column
- START_Y, 384, serve row
- VMAX, 8, maximum speed per axis in pixels/frame
- FRICTION_FRAMES, 16, frames between speed decrements
- PAUSE_FRAMES, 60, frames the puck is held after a goal
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk_in  in  1  pixel clock, the only clock
- rst_n  in  1  asynchronous, active-low reset
- vblnk_in  in  1  vertical blank from the VGA timing chain
- xpos_p1, ypos_p1  in  12 each  player-1 mallet centre
- xpos_p2, ypos_p2  in  12 each  player-2 mallet centre
- radius_player  in  8  mallet radius
- xpos, ypos  out  12 each  puck centre, consumed by the ball draw stage
- vel_x, vel_y  out  6 each  signed two's-complement velocity
- goal_left, goal_right  out  1 each  one-cycle pulse when the puck enters the left or right goal

Function
REQ-003 Frame tick SHALL be a rising edge of vblnk_in, detected against a registered copy of vblnk_in.
REQ-004 FSM states SHALL be IDLE, MOVE, WALL, HIT1, HIT2 and PAUSE.
- IDLE moves to MOVE on a frame tick.
- MOVE, WALL and HIT1 each advance unconditionally after 1 cycle.
- HIT2 moves to IDLE.
- Frame ticks outside IDLE and PAUSE SHALL be ignored.
REQ-005 MOVE SHALL register xpos+vel_x and ypos+vel_y, computed as 13-bit signed, so that xpos/ypos change exactly 2 clk_in edges after the edge that samples the tick.
REQ-006 WALL, horizontal axis:
- If x <= RADIUS and y is in [GOAL_TOP, GOAL_BOT] inclusive, assert goal_left.
- If x >= H_MAX-RADIUS and y is in that window, assert goal_right.
- Otherwise, when a side limit is crossed, clamp x to RADIUS or H_MAX-RADIUS and negate vel_x.
REQ-007 WALL, vertical axis: if y <= RADIUS or y >= V_MAX-RADIUS, clamp y to that limit and negate vel_y; a corner hit SHALL apply both axes in the same cycle.
REQ-008 Goal handling:
- The goal pulse SHALL last exactly 1 cycle.
- The same cycle SHALL load xpos=START_X, ypos=START_Y and zero both velocities.
- The FSM SHALL then go to PAUSE, skipping HIT1 and HIT2.
- A goal therefore takes precedence over mallet hits in the same frame.
REQ-009 HIT1 and HIT2 SHALL test player 1 and player 2 respectively.
- Hit condition: dx²+dy² <= (RADIUS+radius_player)², with dx = xpos−player x and dy = ypos−player y, as signed 13-bit values and unsigned 26-bit squares.
- On a hit: vel_x = sign(dx)·VMAX, or unchanged if dx=0.
- On a hit: vel_y = sign(dy)·(VMAX>>1), or 0 if dy=0.
- If both mallets hit in the same frame, the HIT2 result SHALL win.
REQ-010 Friction:
- A frame counter SHALL wrap at FRICTION_FRAMES-1.
- At wrap, in the HIT2 cycle, each nonzero velocity component SHALL move 1 toward 0, after any hit update.
- Velocities SHALL always stay within [-VMAX, +VMAX].
REQ-011 PAUSE:
- The state SHALL count frame ticks.
- After PAUSE_FRAMES ticks it SHALL return to IDLE.
- The puck SHALL not move and mallet hits SHALL be ignored while in PAUSE.

Reset
REQ-012 rst_n low SHALL immediately, without waiting for clk_in, force:
- xpos=START_X and ypos=START_Y
- vel_x=vel_y=0
- goal_left=goal_right=0
- state IDLE
- frame and pause counters to 0
- registered vblnk cleared to 0
REQ-013 Reset asserted mid-frame or mid-PAUSE SHALL abandon the operation with no goal pulse; the first tick after release SHALL be processed normally.

Verification
REQ-014 Reset: assert rst_n=0 asynchronously between clock edges -> xpos=512, ypos=384, velocities 0 before the next edge.
REQ-015 Free motion: pos (512,384), vel (+3,-2), one vblnk rise -> (515,382) two edges after the tick is sampled; no goal pulse.
REQ-016 Wall bounce: pos (1010,100), vel (+8,0) -> xpos=1013, vel_x=-8.
REQ-017 Goal: pos (15,384), vel (-8,0) -> goal_left high for exactly 1 cycle, puck at (512,384) with vel 0, puck unchanged through 60 ticks even with a mallet overlapping it.
REQ-018 Mallet hit: radius_player=20, player 1 at (500,384), puck (520,390) -> vel (+8,+4); with player 2 also overlapping from the right -> vel_x=-8.
REQ-019 Friction: vel (+5,-1), no hits, 16 ticks -> vel (+4,0).

Source files
------------

// File: rtl/ball_ctl.sv
// Air-hockey puck controller: one position/velocity update per video frame, driven by mallet and wall collisions.
// Latency: position settles 2 clk_in edges after the tick-sampling edge; velocity final 4 edges after it.
// No backpressure: frame ticks arriving while an update or the post-goal pause is in flight are not queued.
module ball_ctl #(
    parameter int RADIUS          = 10,
    parameter int H_MAX           = 1023,
    parameter int V_MAX           = 767,
    parameter int GOAL_TOP        = 284,
    parameter int GOAL_BOT        = 484,
    parameter int START_X         = 512,
    parameter int START_Y         = 384,
    parameter int VMAX            = 8,
    parameter int FRICTION_FRAMES = 16,
    parameter int PAUSE_FRAMES    = 60
) (
    input  logic        clk_in,
    input  logic        rst_n,
    input  logic        vblnk_in,
    input  logic [11:0] xpos_p1,
    input  logic [11:0] ypos_p1,
    input  logic [11:0] xpos_p2,
    input  logic [11:0] ypos_p2,
    input  logic [7:0]  radius_player,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic [5:0]  vel_x,
    output logic [5:0]  vel_y,
    output logic        goal_left,
    output logic        goal_right
);

    localparam int FW = (FRICTION_FRAMES > 1) ? $clog2(FRICTION_FRAMES) : 1;
    localparam int PW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
    localparam logic [FW-1:0] FR_LAST = FW'(FRICTION_FRAMES - 1);
    localparam logic [PW-1:0] PS_LAST = PW'(PAUSE_FRAMES - 1);

    // Signed 13-bit limits so positions pushed past 0 by a negative velocity compare correctly.
    localparam logic signed [12:0] X_LO  = 13'(RADIUS);
    localparam logic signed [12:0] X_HI  = 13'(H_MAX - RADIUS);
    localparam logic signed [12:0] Y_LO  = 13'(RADIUS);
    localparam logic signed [12:0] Y_HI  = 13'(V_MAX - RADIUS);
    localparam logic signed [12:0] G_TOP = 13'(GOAL_TOP);
    localparam logic signed [12:0] G_BOT = 13'(GOAL_BOT);

    localparam logic signed [5:0] V_POS  = 6'(VMAX);
    localparam logic signed [5:0] V_NEG  = -6'(VMAX);
    localparam logic signed [5:0] VH_POS = 6'(VMAX >> 1);
    localparam logic signed [5:0] VH_NEG = -6'(VMAX >> 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MOVE,
        ST_WALL,
        ST_HIT1,
        ST_HIT2,
        ST_PAUSE
    } state_t;

    state_t             state_q;
    logic               vblnk_q;
    logic [11:0]        xpos_q, ypos_q;
    logic signed [5:0]  velx_q, vely_q;
    logic signed [12:0] nx_q, ny_q;
    logic               goal_left_q, goal_right_q;
    logic [FW-1:0]      frame_q;
    logic [PW-1:0]      pause_q;

    logic               tick;
    logic signed [12:0] sum_x, sum_y;

    assign tick  = vblnk_in & ~vblnk_q;
    assign sum_x = {1'b0, xpos_q} + {{7{velx_q[5]}}, velx_q};
    assign sum_y = {1'b0, ypos_q} + {{7{vely_q[5]}}, vely_q};

    // Wall stage: goal detection on the side walls, otherwise clamp and reflect on each axis.
    logic               goal_l_d, goal_r_d, in_win;
    logic [11:0]        wall_x_d, wall_y_d;
    logic signed [5:0]  wall_vx_d, wall_vy_d;

    always_comb begin
        in_win    = (ny_q >= G_TOP) && (ny_q <= G_BOT);
        goal_l_d  = 1'b0;
        goal_r_d  = 1'b0;
        wall_x_d  = nx_q[11:0];
        wall_y_d  = ny_q[11:0];
        wall_vx_d = velx_q;
        wall_vy_d = vely_q;
        if (nx_q <= X_LO) begin
            if (in_win) begin
                goal_l_d = 1'b1;
            end else begin
                wall_x_d  = 12'(RADIUS);
                wall_vx_d = -velx_q;
            end
        end else if (nx_q >= X_HI) begin
            if (in_win) begin
                goal_r_d = 1'b1;
            end else begin
                wall_x_d  = 12'(H_MAX - RADIUS);
                wall_vx_d = -velx_q;
            end
        end
        if (ny_q <= Y_LO) begin
            wall_y_d  = 12'(RADIUS);
            wall_vy_d = -vely_q;
        end else if (ny_q >= Y_HI) begin
            wall_y_d  = 12'(V_MAX - RADIUS);
            wall_vy_d = -vely_q;
        end
    end

    // Mallet stage: one distance test shared by HIT1 (player 1) and HIT2 (player 2), then friction.
    logic [11:0]        px, py;
    logic signed [12:0] dx, dy;
    logic [11:0]        adx, ady;
    logic [25:0]        adx_w, ady_w, dist2_d, rsum_d, rsum2_d;
    logic               hit_d;
    logic signed [5:0]  hit_vx_d, hit_vy_d, vx_h_d, vy_h_d, vx_f_d, vy_f_d;

    always_comb begin
        px = xpos_p2;
        py = ypos_p2;
        if (state_q == ST_HIT1) begin
            px = xpos_p1;
            py = ypos_p1;
        end
        dx      = {1'b0, xpos_q} - {1'b0, px};
        dy      = {1'b0, ypos_q} - {1'b0, py};
        adx     = dx[12] ? 12'(-dx) : dx[11:0];
        ady     = dy[12] ? 12'(-dy) : dy[11:0];
        adx_w   = {14'b0, adx};
        ady_w   = {14'b0, ady};
        dist2_d = adx_w * adx_w + ady_w * ady_w;
        rsum_d  = 26'(RADIUS) + {18'b0, radius_player};
        rsum2_d = rsum_d * rsum_d;
        hit_d   = (dist2_d <= rsum2_d);

        hit_vx_d = velx_q;
        if (dx != 13'sd0) hit_vx_d = dx[12] ? V_NEG : V_POS;
        hit_vy_d = 6'sd0;
        if (dy != 13'sd0) hit_vy_d = dy[12] ? VH_NEG : VH_POS;

        vx_h_d = hit_d ? hit_vx_d : velx_q;
        vy_h_d = hit_d ? hit_vy_d : vely_q;

        vx_f_d = 6'sd0;
        if (vx_h_d != 6'sd0) vx_f_d = vx_h_d[5] ? vx_h_d + 6'sd1 : vx_h_d - 6'sd1;
        vy_f_d = 6'sd0;
        if (vy_h_d != 6'sd0) vy_f_d = vy_h_d[5] ? vy_h_d + 6'sd1 : vy_h_d - 6'sd1;
    end

    // Frame sequencer: owns all puck state, counters and the registered goal pulses.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vblnk_q      <= 1'b0;
            xpos_q       <= 12'(START_X);
            ypos_q       <= 12'(START_Y);
            velx_q       <= 6'sd0;
            vely_q       <= 6'sd0;
            nx_q         <= 13'sd0;
            ny_q         <= 13'sd0;
            goal_left_q  <= 1'b0;
            goal_right_q <= 1'b0;
            frame_q      <= '0;
            pause_q      <= '0;
        end else begin
            vblnk_q      <= vblnk_in;
            goal_left_q  <= 1'b0;
            goal_right_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (tick) state_q <= ST_MOVE;
                end
                ST_MOVE: begin
                    nx_q    <= sum_x;
                    ny_q    <= sum_y;
                    state_q <= ST_WALL;
                end
                ST_WALL: begin
                    if (goal_l_d || goal_r_d) begin
                        // Goal beats any mallet contact this frame: re-serve and hold.
                        goal_left_q  <= goal_l_d;
                        goal_right_q <= goal_r_d;
                        xpos_q       <= 12'(START_X);
                        ypos_q       <= 12'(START_Y);
                        velx_q       <= 6'sd0;
                        vely_q       <= 6'sd0;
                        pause_q      <= '0;
                        state_q      <= ST_PAUSE;
                    end else begin
                        xpos_q  <= wall_x_d;
                        ypos_q  <= wall_y_d;
                        velx_q  <= wall_vx_d;
                        vely_q  <= wall_vy_d;
                        state_q <= ST_HIT1;
                    end
                end
                ST_HIT1: begin
                    if (hit_d) begin
                        velx_q <= hit_vx_d;
                        vely_q <= hit_vy_d;
                    end
                    state_q <= ST_HIT2;
                end
                ST_HIT2: begin
                    if (frame_q == FR_LAST) begin
                        frame_q <= '0;
                        velx_q  <= vx_f_d;
                        vely_q  <= vy_f_d;
                    end else begin
                        frame_q <= frame_q + FW'(1);
                        velx_q  <= vx_h_d;
                        vely_q  <= vy_h_d;
                    end
                    state_q <= ST_IDLE;
                end
                ST_PAUSE: begin
                    if (tick) begin
                        if (pause_q == PS_LAST) begin
                            pause_q <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            pause_q <= pause_q + PW'(1);
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign xpos       = xpos_q;
    assign ypos       = ypos_q;
    assign vel_x      = velx_q;
    assign vel_y      = vely_q;
    assign goal_left  = goal_left_q;
    assign goal_right = goal_right_q;

endmodule

// File: tb/tb_ball_ctl.sv
// Directed-frame bench for ball_ctl: each frame tick pushes the expected puck state into a scoreboard queue.
// A monitor watching vblnk_in pops one entry per tick and compares position timing, velocity and goal pulses.
// Resets are applied between clock edges and checked before the next edge.
module tb_ball_ctl;

    logic        clk_in = 1'b0;
    logic        rst_n = 1'b0;
    logic        vblnk_in = 1'b0;
    logic [11:0] xpos_p1 = 12'd4000, ypos_p1 = 12'd4000;
    logic [11:0] xpos_p2 = 12'd4000, ypos_p2 = 12'd4000;
    logic [7:0]  radius_player = 8'd20;
    logic [11:0] xpos, ypos;
    logic [5:0]  vel_x, vel_y;
    logic        goal_left, goal_right;

    ball_ctl dut (
        .clk_in(clk_in), .rst_n(rst_n), .vblnk_in(vblnk_in),
        .xpos_p1(xpos_p1), .ypos_p1(ypos_p1), .xpos_p2(xpos_p2), .ypos_p2(ypos_p2),
        .radius_player(radius_player),
        .xpos(xpos), .ypos(ypos), .vel_x(vel_x), .vel_y(vel_y),
        .goal_left(goal_left), .goal_right(goal_right)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int ox, oy, x, y, vx, vy, gl, gr;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    // Reference puck state, frame-level.
    int mx, my, mvx, mvy, mframe, mpause;

    localparam int PARK = 4000;

    task automatic check(input string name, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        mx = 512; my = 384; mvx = 0; mvy = 0; mframe = 0; mpause = 0;
    endtask

    task automatic model_hit(input int px, input int py);
        int dx, dy, r;
        dx = mx - px;
        dy = my - py;
        r  = 10 + int'(radius_player);
        if (dx * dx + dy * dy <= r * r) begin
            if (dx > 0) mvx = 8;
            else if (dx < 0) mvx = -8;
            if (dy > 0) mvy = 4;
            else if (dy < 0) mvy = -4;
            else mvy = 0;
        end
    endtask

    function automatic int toward_zero(input int v);
        if (v > 0) return v - 1;
        if (v < 0) return v + 1;
        return 0;
    endfunction

    task automatic model_tick(output int gl, output int gr);
        int nx, ny;
        bit win;
        gl = 0;
        gr = 0;
        if (mpause > 0) begin
            mpause--;
        end else begin
            nx  = mx + mvx;
            ny  = my + mvy;
            win = (ny >= 284) && (ny <= 484);
            if (nx <= 10 && win) begin
                gl = 1;
                mx = 512; my = 384; mvx = 0; mvy = 0; mpause = 60;
            end else if (nx >= 1013 && win) begin
                gr = 1;
                mx = 512; my = 384; mvx = 0; mvy = 0; mpause = 60;
            end else begin
                if (nx <= 10) begin nx = 10; mvx = -mvx; end
                else if (nx >= 1013) begin nx = 1013; mvx = -mvx; end
                if (ny <= 10) begin ny = 10; mvy = -mvy; end
                else if (ny >= 757) begin ny = 757; mvy = -mvy; end
                mx = nx;
                my = ny;
                model_hit(int'(xpos_p1), int'(ypos_p1));
                model_hit(int'(xpos_p2), int'(ypos_p2));
                if (mframe == 15) begin
                    mframe = 0;
                    mvx = toward_zero(mvx);
                    mvy = toward_zero(mvy);
                end else begin
                    mframe++;
                end
            end
        end
    endtask

    // One video frame: place mallets, record the expected outcome, then pulse vblank.
    task automatic frame(input int x1, input int y1, input int x2, input int y2);
        exp_t e;
        int gl, gr;
        xpos_p1 = 12'(x1); ypos_p1 = 12'(y1);
        xpos_p2 = 12'(x2); ypos_p2 = 12'(y2);
        e.ox = mx; e.oy = my;
        model_tick(gl, gr);
        e.x = mx; e.y = my; e.vx = mvx; e.vy = mvy; e.gl = gl; e.gr = gr;
        exp_q.push_back(e);
        @(negedge clk_in);
        vblnk_in = 1'b1;
        repeat (3) @(negedge clk_in);
        vblnk_in = 1'b0;
        repeat (14) @(negedge clk_in);
    endtask

    task automatic free_frame();
        frame(PARK, PARK, PARK, PARK);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must be at serve values before the next edge.
    task automatic do_reset(input string tag);
        @(negedge clk_in);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_xpos"}, int'(xpos), 512);
        check({tag, "_ypos"}, int'(ypos), 384);
        check({tag, "_velx"}, int'($signed(vel_x)), 0);
        check({tag, "_vely"}, int'($signed(vel_y)), 0);
        check({tag, "_goall"}, int'(goal_left), 0);
        check({tag, "_goalr"}, int'(goal_right), 0);
        model_reset();
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (2) @(negedge clk_in);
    endtask

    // Monitor: one scoreboard entry consumed per vblank rising edge seen at a clock edge.
    initial begin : monitor
        bit   prev;
        bit   have;
        int   gl, gr;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(posedge clk_in);
            if (rst_n && vblnk_in && !prev) begin
                gl = 0;
                gr = 0;
                have = (exp_q.size() != 0);
                if (have) begin
                    e = exp_q.pop_front();
                end else begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got tick, want queued entry (t=%0t)", $time);
                end
                for (int k = 1; k <= 7; k++) begin
                    @(negedge clk_in);
                    gl += int'(goal_left);
                    gr += int'(goal_right);
                    if (have && k == 2) begin
                        check("xpos_hold", int'(xpos), e.ox);
                        check("ypos_hold", int'(ypos), e.oy);
                    end
                    if (have && k == 3) begin
                        check("xpos_new", int'(xpos), e.x);
                        check("ypos_new", int'(ypos), e.y);
                    end
                end
                if (have) begin
                    check("vel_x", int'($signed(vel_x)), e.vx);
                    check("vel_y", int'($signed(vel_y)), e.vy);
                    check("goal_left_cycles", gl, e.gl);
                    check("goal_right_cycles", gr, e.gr);
                end
                prev = 1'b1;
            end else begin
                prev = vblnk_in;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        model_reset();
        #13;
        check("init_xpos", int'(xpos), 512);
        check("init_ypos", int'(ypos), 384);
        check("init_velx", int'($signed(vel_x)), 0);
        check("init_goall", int'(goal_left), 0);
        @(negedge clk_in);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_in);

        // Idle puck stays put; then p1 strikes from up-left: vel (+8,+4).
        free_frame();
        frame(500, 378, PARK, PARK);
        free_frame();
        // Both mallets touch: p1 pushes right, p2 (right side) wins -> vel (-8,+4).
        frame(500, 384, 540, 388);

        // Glide left under friction into the left wall below the goal mouth.
        for (int i = 0; i < 110; i++) free_frame();

        // Repeated pushes to the right drive the puck into the right wall.
        for (int r = 0; r < 4; r++) begin
            frame(mx - 12, my, PARK, PARK);
            for (int i = 0; i < 40; i++) free_frame();
        end

        // Serve again and shoot into the left goal.
        do_reset("rst_mid");
        frame(524, 384, PARK, PARK);
        n = 0;
        while (mpause != 60 && n < 80) begin
            free_frame();
            n++;
        end
        // Held through the pause even with a mallet overlapping the serve spot.
        for (int i = 0; i < 60; i++) frame(500, 384, PARK, PARK);
        // First tick after the pause is live again.
        frame(500, 384, PARK, PARK);
        free_frame();

        // Right goal, then reset in the middle of the pause.
        do_reset("rst_goal");
        frame(500, 384, PARK, PARK);
        n = 0;
        while (mpause != 60 && n < 80) begin
            free_frame();
            n++;
        end
        for (int i = 0; i < 5; i++) free_frame();
        do_reset("rst_pause");
        frame(500, 390, PARK, PARK);
        free_frame();

        repeat (10) @(negedge clk_in);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
